// File: rtl/l2_req_arb.sv
// l2_req_arb: round-robin host request arbiter with per-stream credits and tag-routed responses
module l2_req_arb #(
  parameter int nstrm = 4,
  parameter int strm_width = $clog2(nstrm),
  parameter int addr_width = 64,
  parameter int max_out = 16,
  parameter int out_width = $clog2(max_out + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [nstrm-1:0]              i_req_v,
  output logic [nstrm-1:0]              i_req_r,
  input  logic [nstrm*addr_width-1:0]   i_req_ea,
  output logic                          o_req_v,
  input  logic                          o_req_r,
  output logic [addr_width-1:0]         o_req_ea,
  output logic [strm_width-1:0]         o_req_tag,
  input  logic                          i_rsp_v,
  output logic                          i_rsp_r,
  input  logic [strm_width-1:0]         i_rsp_tag,
  output logic [nstrm-1:0]              o_rsp_v,
  input  logic [nstrm-1:0]              o_rsp_r,
  output logic                          o_idle
);
  logic                  r_full;
  logic [addr_width-1:0] r_ea;
  logic [strm_width-1:0] r_tag, r_last, w_gnt_idx;
  logic [out_width-1:0]  r_cnt [nstrm];
  logic [nstrm-1:0]      w_elig, w_rot, w_hit, w_rsp_hs, w_dec, w_cnt_zero;
  logic [strm_width:0]   w_k, w_sum;
  logic                  w_load, w_gnt_v, w_grant;
  assign w_load     = ~r_full | o_req_r;
  assign w_grant    = w_load & w_gnt_v;
  assign i_req_r    = w_grant ? nstrm'(1) << w_gnt_idx : '0;
  assign o_req_v    = r_full;
  assign o_req_ea   = r_ea;
  assign o_req_tag  = r_tag;
  assign o_rsp_v    = i_rsp_v ? w_hit : '0;
  // A tag matching no stream is accepted and dropped
  assign i_rsp_r    = ~|w_hit | |(w_hit & o_rsp_r);
  assign w_rsp_hs   = o_rsp_v & o_rsp_r;
  assign w_dec      = w_rsp_hs & ~w_cnt_zero;
  assign o_idle     = ~r_full & &w_cnt_zero;
  // Bit k of w_rot is the stream k+1 places after the last grant
  assign w_rot = nstrm'({w_elig, w_elig} >> ({1'b0, r_last} + (strm_width+1)'(1)));
  for (genvar g = 0; g < nstrm; g++) begin : g_strm
    assign w_elig[g]     = i_req_v[g] & (r_cnt[g] < out_width'(max_out));
    assign w_hit[g]      = i_rsp_tag == strm_width'(g);
    assign w_cnt_zero[g] = r_cnt[g] == '0;
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(w_rsp_hs[g] && w_cnt_zero[g]));
  end
  always_comb begin
    w_gnt_v = |w_rot;
    w_k = '0;
    for (int k = nstrm - 1; k >= 0; k--) w_k = w_rot[k] ? (strm_width+1)'(k) : w_k;
    w_sum = {1'b0, r_last} + w_k + (strm_width+1)'(1);
    w_gnt_idx = strm_width'(w_sum >= (strm_width+1)'(nstrm) ? w_sum - (strm_width+1)'(nstrm) : w_sum);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_ea   <= '0;
      r_tag  <= '0;
      r_last <= strm_width'(nstrm - 1);
    end else if (w_load) begin
      r_full <= w_gnt_v;
      if (w_gnt_v) begin
        r_ea   <= i_req_ea[w_gnt_idx*addr_width +: addr_width];
        r_tag  <= w_gnt_idx;
        r_last <= w_gnt_idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < nstrm; s++) r_cnt[s] <= '0;
    end else begin
      for (int s = 0; s < nstrm; s++) begin
        if (i_req_r[s] & ~w_dec[s]) r_cnt[s] <= r_cnt[s] + out_width'(1);
        else if (~i_req_r[s] & w_dec[s]) r_cnt[s] <= r_cnt[s] - out_width'(1);
      end
    end
  end
endmodule

// File: tb/tb_l2_req_arb.sv
// tb_l2_req_arb: directed and random stimulus against a cycle-level model of the arbiter
module tb_l2_req_arb;
  localparam int N = 4, AW = 64, MO = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] i_req_v = '0, i_req_r, o_rsp_v, o_rsp_r = '0;
  logic [N*AW-1:0] i_req_ea = '0;
  logic o_req_v, o_req_r = 1'b0, i_rsp_v = 1'b0, i_rsp_r, o_idle;
  logic [AW-1:0] o_req_ea;
  logic [1:0] o_req_tag, i_rsp_tag = '0;
  int n_chk = 0, n_fail = 0;
  int m_cnt [N];
  bit m_full;
  logic [AW-1:0] m_ea;
  int m_tag, m_last;
  int obs_q[$];

  l2_req_arb dut (
    .clk(clk), .reset(reset), .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_ea(i_req_ea),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_tag(o_req_tag),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag), .o_rsp_v(o_rsp_v),
    .o_rsp_r(o_rsp_r), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit idle_exp();
    int tot = 0;
    for (int s = 0; s < N; s++) tot += m_cnt[s];
    return !m_full && tot == 0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_full = 0; m_ea = '0; m_tag = 0; m_last = N - 1;
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
    obs_q.delete();
    chk("rst_req_v", o_req_v, 0);
    chk("rst_req_ea", o_req_ea, 0);
    chk("rst_req_tag", o_req_tag, 0);
    chk("rst_idle", o_idle, 1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic cyc();
    int g = -1;
    bit ld;
    #1;
    ld = !m_full || o_req_r;
    if (ld)
      for (int k = 1; k <= N; k++) begin
        int s = (m_last + k) % N;
        if (g < 0 && i_req_v[s] && m_cnt[s] < MO) g = s;
      end
    chk("req_r", i_req_r, g >= 0 ? 64'd1 << g : 64'd0);
    chk("rsp_v", o_rsp_v, i_rsp_v ? 64'd1 << i_rsp_tag : 64'd0);
    chk("rsp_r", i_rsp_r, o_rsp_r[i_rsp_tag]);
    for (int s = 0; s < N; s++) if (i_req_r[s]) obs_q.push_back(s);
    if (i_rsp_v && o_rsp_r[i_rsp_tag] && m_cnt[i_rsp_tag] > 0) m_cnt[i_rsp_tag]--;
    if (g >= 0) m_cnt[g]++;
    if (ld) begin
      m_full = g >= 0;
      if (g >= 0) begin
        m_ea = i_req_ea[g*AW +: AW];
        m_tag = g;
        m_last = g;
      end
    end
    @(posedge clk);
    #1;
    chk("req_v", o_req_v, m_full);
    chk("req_ea", o_req_ea, m_ea);
    chk("req_tag", o_req_tag, m_tag);
    chk("idle", o_idle, idle_exp());
    @(negedge clk);
  endtask

  initial begin
    int n0, stable_tag;
    int live[$];
    logic [AW-1:0] stable_ea;
    @(negedge clk);
    do_reset();
    // single stream back to back
    o_req_r = 1; i_req_v = 4'b0010; i_req_ea[1*AW +: AW] = 64'h1000;
    cyc();
    i_req_ea[1*AW +: AW] = 64'h1080;
    cyc();
    i_req_v = '0;
    cyc();
    chk("single_grants", obs_q.size(), 2);
    chk("single_tag", obs_q[1], 1);
    // fairness
    do_reset();
    i_req_v = 4'hf;
    for (int s = 0; s < N; s++) i_req_ea[s*AW +: AW] = 64'h100 * (s + 1);
    for (int i = 0; i < 8; i++) cyc();
    chk("fair_count", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("fair_order", obs_q[i], i % 4);
    // backpressure: register stays put and nothing is granted
    o_req_r = 0;
    stable_ea = o_req_ea; stable_tag = o_req_tag;
    n0 = obs_q.size();
    for (int i = 0; i < 5; i++) cyc();
    chk("bp_no_grant", obs_q.size(), n0);
    chk("bp_ea", o_req_ea, stable_ea);
    chk("bp_tag", o_req_tag, stable_tag);
    o_req_r = 1;
    cyc();
    chk("bp_release_grant", obs_q.size(), n0 + 1);
    // credit limit
    do_reset();
    i_req_v = 4'b0001; o_req_r = 1;
    for (int i = 0; i < 20; i++) cyc();
    chk("credit_grants", obs_q.size(), MO);
    i_rsp_v = 1; i_rsp_tag = 0; o_rsp_r = 4'b0001;
    cyc();
    chk("credit_rsp_cycle", obs_q.size(), MO);
    i_rsp_v = 0; o_rsp_r = '0;
    cyc();
    chk("credit_17th", obs_q.size(), MO + 1);
    // response routing
    do_reset();
    i_req_v = 4'b0100;
    for (int i = 0; i < 3; i++) cyc();
    i_req_v = '0; i_rsp_v = 1; i_rsp_tag = 2; o_rsp_r = 4'b1011;
    cyc();
    chk("route_not_ready", i_rsp_r, 0);
    o_rsp_r = 4'b0100;
    for (int i = 0; i < 3; i++) cyc();
    i_rsp_v = 0;
    cyc();
    chk("route_drained_idle", o_idle, 1);
    // simultaneous grant and response, then reset with a request pending
    do_reset();
    i_req_v = 4'b1000;
    cyc();
    i_rsp_v = 1; i_rsp_tag = 3; o_rsp_r = 4'b1000;
    cyc();
    i_rsp_v = 0; o_req_r = 0;
    cyc();
    chk("pending_before_reset", o_req_v, 1);
    do_reset();
    i_req_v = 4'hf; o_req_r = 1;
    cyc();
    chk("first_after_reset", obs_q[0], 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      i_req_v = N'($urandom);
      for (int s = 0; s < N; s++) i_req_ea[s*AW +: AW] = {$urandom, $urandom};
      o_req_r = $urandom_range(0, 3) != 0;
      o_rsp_r = N'($urandom);
      live.delete();
      for (int s = 0; s < N; s++) if (m_cnt[s] > 0) live.push_back(s);
      if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
        i_rsp_v = 1;
        i_rsp_tag = 2'(live[$urandom_range(0, live.size() - 1)]);
      end else begin
        i_rsp_v = 0;
        i_rsp_tag = 2'($urandom_range(0, 3));
      end
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
